encoder_serial_priority: RTL
============================

Name: encoder_serial_priority

Overview:
- Parametrised successor to the team's 8-to-3 one-hot encoder.
- Accepts an N-line request vector, which may be one-hot or multi-hot, over a valid/ready handshake.
- Emits the binary index of every set line, one per handshake, in a fixed priority order.
- Sits between interrupt/event request lines and a single downstream consumer of encoded indices. It replaces the combinational encoder wherever more than one line can be active at once.

Parameters:
- N_LINES, 8, number of input request lines; legal range 2..256.
- OUT_W, 3, index width; must equal ceil(log2(N_LINES)). Violation is an elaboration-time error.
- MSB_FIRST, 0, priority order. 0: lowest set index is emitted first. 1: highest set index is emitted first.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_lines  input  N_LINES  request vector, sampled on accept.
- in_valid  input  1  in_lines is valid.
- in_ready  output  1  block can accept a vector.
- out_lines  output  OUT_W  encoded index of the current highest-priority pending line.
- out_valid  output  1  out_lines is valid.
- out_ready  input  1  downstream accepts out_lines.
- out_last  output  1  current index is the final one for the captured vector.
- out_total  output  OUT_W+1  popcount of the captured vector; held for the whole burst.
- err_zero  output  1  one-cycle pulse: an all-zero vector was accepted.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; pending=0.
  - out_valid=0, out_lines=0, out_last=0, out_total=0, err_zero=0.
  - in_ready=1 from the first clock after deassertion.
  - Reset mid-burst discards all pending lines; no further out_valid until a new vector is accepted.
- State IDLE:
  - in_ready=1, out_valid=0.
  - Accept occurs when in_valid && in_ready at a rising edge.
  - Accept with in_lines!=0: pending<=in_lines; out_total<=popcount(in_lines); go to EMIT.
  - Accept with in_lines==0: err_zero=1 for exactly the next cycle; stay in IDLE; out_total unchanged.
- State EMIT:
  - in_ready=0; out_valid=1.
  - out_lines is the index of the lowest set bit of pending (MSB_FIRST=0) or the highest set bit (MSB_FIRST=1). It is decoded combinationally from the pending register.
  - out_last=1 iff popcount(pending)==1.
  - Handshake (out_valid && out_ready): the emitted bit is cleared in pending.
  - If out_last, go to IDLE; in_ready=1 in the following cycle. There is no same-cycle re-accept.
- Latency:
  - First out_valid occurs in the cycle after accept.
  - Subsequent indices follow one per cycle while out_ready=1.
  - A full-vector burst takes popcount cycles of handshakes.
- Backpressure: while out_ready=0, out_lines, out_last, out_total and pending are held stable. out_valid is never withdrawn before its handshake.
- Outside EMIT: out_lines=0 and out_last=0. No x values are driven; this replaces the old default-x behaviour.
- in_lines/in_valid changes during EMIT are ignored.
- Width rules:
  - out_total is OUT_W+1 bits so that an all-ones N_LINES=2^OUT_W vector is counted without overflow (e.g. 8 for N=8).
  - If N_LINES is not a power of 2, indices >= N_LINES never appear.

Test Plan:
- Each one-hot input 8'b00000001..8'b10000000, out_ready=1 -> out_lines=0..7 respectively; out_last=1, out_total=1; one out_valid cycle per vector, one cycle after accept.
- in_lines=8'b10100100, MSB_FIRST=0, out_ready=1 -> out_lines 2,5,7 on consecutive cycles; out_last only on 7; out_total=3; in_ready returns 1 the cycle after 7.
- Same vector with MSB_FIRST=1 -> 7,5,2. Then in_lines=8'hFF -> 8 indices 7..0; out_total=4'd8.
- in_lines=8'b00011000 with out_ready held low 5 cycles -> out_lines=3 stable and out_valid=1 throughout; in_ready=0; in_lines changed to 8'h01 meanwhile is ignored. After out_ready rises: 3 then 4.
- in_valid=1, in_lines=0 in IDLE -> err_zero pulses exactly 1 cycle; out_valid stays 0; in_ready stays 1.
- in_lines=8'b11110000 accepted, rst_n pulsed low after the second index -> outputs immediately 0/IDLE. After release, accept 8'h02 -> single index 1 with out_total=1.

Source files
------------

// File: rtl/encoder_serial_priority_if.sv
// encoder_serial_priority_if: request-vector input and encoded-index output handshakes.
interface encoder_serial_priority_if #(
   parameter int N_LINES = 8,
   parameter int OUT_W   = 3
);
   logic [N_LINES-1:0] in_lines;
   logic               in_valid;
   logic               in_ready;
   logic [OUT_W-1:0]   out_lines;
   logic               out_valid;
   logic               out_ready;
   logic               out_last;
   logic [OUT_W:0]     out_total;
   logic               err_zero;
   modport master (
      output in_lines, in_valid, out_ready,
      input  in_ready, out_lines, out_valid, out_last, out_total, err_zero
   );
   modport slave (
      input  in_lines, in_valid, out_ready,
      output in_ready, out_lines, out_valid, out_last, out_total, err_zero
   );
endinterface

// File: rtl/encoder_serial_priority.sv
// encoder_serial_priority: captures a multi-hot request vector and emits the index of
// each set line, one per output handshake, in fixed priority order.
module encoder_serial_priority #(
   parameter int N_LINES   = 8,
   parameter int OUT_W     = 3,
   parameter bit MSB_FIRST = 1'b0
) (
   input logic clk,
   input logic rst_n,
   encoder_serial_priority_if.slave bus
);
   if (OUT_W != $clog2(N_LINES) || N_LINES < 2 || N_LINES > 256) begin : g_bad_params
      $error("encoder_serial_priority: OUT_W must equal clog2(N_LINES), N_LINES in 2..256");
   end
   typedef enum logic {IDLE, EMIT} state_t;
   state_t             state, state_nx;
   logic [N_LINES-1:0] pending, pending_nx;
   logic [OUT_W:0]     total, total_nx;
   logic               err, err_nx;
   logic [OUT_W-1:0]   idx;
   logic               single;
   function automatic logic [OUT_W:0] popcount(input logic [N_LINES-1:0] v);
      popcount = '0;
      for (int i = 0; i < N_LINES; i++) popcount += (OUT_W+1)'(v[i]);
   endfunction
   // The last match in scan order wins, so scan away from the priority end.
   always_comb begin
      idx = '0;
      for (int i = 0; i < N_LINES; i++)
         if (pending[MSB_FIRST ? i : N_LINES-1-i]) idx = OUT_W'(MSB_FIRST ? i : N_LINES-1-i);
   end
   assign single = (pending & (pending - 1'b1)) == '0;
   always_comb begin
      state_nx   = state;
      pending_nx = pending;
      total_nx   = total;
      err_nx     = 1'b0;
      if (state == IDLE) begin
         if (bus.in_valid && |bus.in_lines) begin
            pending_nx = bus.in_lines;
            total_nx   = popcount(bus.in_lines);
            state_nx   = EMIT;
         end
         err_nx = bus.in_valid && bus.in_lines == '0;
      end else if (bus.out_ready) begin
         pending_nx[idx] = 1'b0;
         state_nx        = single ? IDLE : EMIT;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pending <= '0;
         total   <= '0;
         err     <= 1'b0;
      end else begin
         state   <= state_nx;
         pending <= pending_nx;
         total   <= total_nx;
         err     <= err_nx;
      end
   end
   assign bus.in_ready  = state == IDLE;
   assign bus.out_valid = state == EMIT;
   assign bus.out_lines = state == EMIT ? idx : '0;
   assign bus.out_last  = state == EMIT && single;
   assign bus.out_total = total;
   assign bus.err_zero  = err;
endmodule
